// File: rtl/serialmul_arb.sv
// serialmul_arb: shares one bit-serial scaling multiplier between two requesters.
// Define SERIALMUL_ARB_RR_EN for round-robin tie-break; otherwise requester 0 has fixed priority.
module serialmul_arb #(
  parameter int WIDTH  = 16,
  parameter int DWIDTH = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic signed [WIDTH-1:0] req0_x,
  input  logic signed [WIDTH-1:0] req0_y,
  input  logic signed [WIDTH-1:0] req0_z,
  input  logic [DWIDTH-1:0]       req0_d,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic signed [WIDTH-1:0] req1_x,
  input  logic signed [WIDTH-1:0] req1_y,
  input  logic signed [WIDTH-1:0] req1_z,
  input  logic [DWIDTH-1:0]       req1_d,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic signed [WIDTH-1:0] rsp_x,
  output logic signed [WIDTH-1:0] rsp_y,
  output logic signed [WIDTH-1:0] rsp_z,
  output logic                    mul_start,
  output logic signed [WIDTH-1:0] mul_x,
  output logic signed [WIDTH-1:0] mul_y,
  output logic signed [WIDTH-1:0] mul_z,
  output logic [DWIDTH-1:0]       mul_d,
  input  logic                    mul_done,
  input  logic signed [WIDTH-1:0] mul_xout,
  input  logic signed [WIDTH-1:0] mul_yout,
  input  logic signed [WIDTH-1:0] mul_zout,
  output logic                    busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_SETTLE,
    S_RESP
  } state_t;

  state_t                  state_q;
  logic                    mul_start_q;
  logic signed [WIDTH-1:0] mul_x_q, mul_y_q, mul_z_q;
  logic [DWIDTH-1:0]       mul_d_q;
  logic                    id_q;
  logic                    rsp_valid_q;
  logic signed [WIDTH-1:0] rsp_x_q, rsp_y_q, rsp_z_q;

  logic prio0;
  logic grant0, grant1;
  logic accept;

`ifdef SERIALMUL_ARB_RR_EN
  // last_q holds the index granted most recently; reset to 1 so requester 0 wins the first tie
  logic last_q;
  logic last_d;

  assign prio0  = last_q;
  assign last_d = accept ? grant1 : last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign prio0 = 1'b1;
`endif

  assign grant0     = req0_valid & (prio0 | ~req1_valid);
  assign grant1     = req1_valid & ~grant0;
  assign req0_ready = (state_q == S_IDLE) & grant0;
  assign req1_ready = (state_q == S_IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mul_start_q <= 1'b0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      mul_z_q     <= '0;
      mul_d_q     <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_x_q     <= '0;
      rsp_y_q     <= '0;
      rsp_z_q     <= '0;
    end else begin
      mul_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            mul_x_q     <= grant1 ? req1_x : req0_x;
            mul_y_q     <= grant1 ? req1_y : req0_y;
            mul_z_q     <= grant1 ? req1_z : req0_z;
            mul_d_q     <= grant1 ? req1_d : req0_d;
            id_q        <= grant1;
            mul_start_q <= 1'b1;
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: begin
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (mul_done) begin
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // multiplier accumulators became final on the edge that ended RUN
          rsp_x_q     <= mul_xout;
          rsp_y_q     <= mul_yout;
          rsp_z_q     <= mul_zout;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mul_start = mul_start_q;
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign mul_z     = mul_z_q;
  assign mul_d     = mul_d_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_x     = rsp_x_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_z     = rsp_z_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_serialmul_arb.sv
// Bench for serialmul_arb: a behavioural bit-serial multiplier answers mul_start/mul_done,
// a scoreboard queue holds expected responses pushed when requests are driven.
module tb_serialmul_arb;
  localparam int W  = 16;
  localparam int DW = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic signed [W-1:0] req0_x, req0_y, req0_z, req1_x, req1_y, req1_z;
  logic [DW-1:0] req0_d, req1_d;
  logic rsp_valid, rsp_ready, rsp_id;
  logic signed [W-1:0] rsp_x, rsp_y, rsp_z;
  logic mul_start, mul_done, busy;
  logic signed [W-1:0] mul_x, mul_y, mul_z;
  logic [DW-1:0] mul_d;
  logic signed [W-1:0] mul_xout = '0;
  logic signed [W-1:0] mul_yout = '0;
  logic signed [W-1:0] mul_zout = '0;
  logic force_done = 1'b0;

  int errors = 0;
  int checks = 0;
  bit model_last = 1'b1;

  typedef struct {
    logic            id;
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [W-1:0] z;
    int              lat;
  } exp_t;
  exp_t sb[$];

  serialmul_arb #(.WIDTH(W), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_x(req0_x), .req0_y(req0_y), .req0_z(req0_z), .req0_d(req0_d),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_x(req1_x), .req1_y(req1_y), .req1_z(req1_z), .req1_d(req1_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
    .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z), .mul_d(mul_d),
    .mul_done(mul_done), .mul_xout(mul_xout), .mul_yout(mul_yout), .mul_zout(mul_zout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int nsteps(input logic [DW-1:0] d);
    int tz;
    tz = DW - 1;
    for (int i = DW - 2; i >= 0; i--) if (d[i]) tz = i;
    return (DW - 1) - tz;
  endfunction

  function automatic logic signed [W-1:0] scale(input logic signed [W-1:0] x, input logic [DW-1:0] d);
    logic signed [W-1:0] acc;
    acc = '0;
    for (int i = 0; i < DW; i++) if (d[DW-1-i]) acc = acc + (x >>> i);
    return acc;
  endfunction

  // Behavioural multiplier: busy for nsteps+1 cycles after the start edge, garbage until final.
  logic m_run = 1'b0;
  int   m_cnt = 0;
  logic signed [W-1:0] m_x = '0, m_y = '0, m_z = '0;
  logic [DW-1:0] m_d = '0;

  always @(posedge clk) begin
    if (mul_start === 1'b1) begin
      m_run    <= 1'b1;
      m_cnt    <= nsteps(mul_d);
      m_x      <= mul_x;
      m_y      <= mul_y;
      m_z      <= mul_z;
      m_d      <= mul_d;
      mul_xout <= 16'sh5A5A;
      mul_yout <= 16'sh6B6B;
      mul_zout <= 16'sh7C7C;
    end else if (m_run) begin
      if (m_cnt == 0) begin
        m_run    <= 1'b0;
        mul_xout <= scale(m_x, m_d);
        mul_yout <= scale(m_y, m_d);
        mul_zout <= scale(m_z, m_d);
      end else begin
        m_cnt    <= m_cnt - 1;
        mul_xout <= mul_xout + 16'sh0111;
        mul_yout <= mul_yout + 16'sh0111;
        mul_zout <= mul_zout + 16'sh0111;
      end
    end
  end

  assign mul_done = (m_run && (m_cnt == 0)) || force_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic run_op(input bit id, input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                        input logic signed [W-1:0] z, input logic [DW-1:0] d,
                        output int lat, output int starts, output bit to);
    int guard;
    to = 1'b0; lat = 0; starts = 0; guard = 0;
    if (id) begin
      req1_valid = 1'b1; req1_x = x; req1_y = y; req1_z = z; req1_d = d;
    end else begin
      req0_valid = 1'b1; req0_x = x; req0_y = y; req0_z = z; req0_d = d;
    end
    #1;
    while (((id ? req1_ready : req0_ready) !== 1'b1) && guard < 40) begin
      tick();
      guard++;
    end
    if (guard >= 40) begin
      to = 1'b1;
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
      return;
    end
    tick();
    model_last = id;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    if (mul_start === 1'b1) starts++;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      if (mul_start === 1'b1) starts++;
    end
    if (rsp_valid !== 1'b1) to = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if ({rsp_valid, busy, mul_start, rsp_id} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got valid/busy/start/id=%b want 0000", {rsp_valid, busy, mul_start, rsp_id});
    end
    checks++;
    if ({mul_x, mul_y, mul_z, mul_d} !== '0) begin
      errors++; $display("FAIL reset_mul_ops: got x=%0d y=%0d z=%0d d=%h want 0", mul_x, mul_y, mul_z, mul_d);
    end
    checks++;
    if ({rsp_x, rsp_y, rsp_z} !== '0) begin
      errors++; $display("FAIL reset_rsp: got %0d %0d %0d want 0 0 0", rsp_x, rsp_y, rsp_z);
    end
  endtask

  task automatic test_unit_scale();
    exp_t e; int lat, st; bit to;
    e.id = 1'b0; e.x = 16'sd1000; e.y = -16'sd2000; e.z = 16'sd32767; e.lat = 3;
    sb.push_back(e);
    run_op(1'b0, 16'sd1000, -16'sd2000, 16'sd32767, 11'h400, lat, st, to);
    e = sb.pop_front();
    checks++;
    if (to || lat !== e.lat) begin
      errors++; $display("FAIL unit_latency: got %0d (timeout=%0b) want %0d", lat, to, e.lat);
    end
    checks++;
    if (rsp_id !== e.id) begin
      errors++; $display("FAIL unit_id: got %b want %b", rsp_id, e.id);
    end
    checks++;
    if ({rsp_x, rsp_y, rsp_z} !== {e.x, e.y, e.z}) begin
      errors++; $display("FAIL unit_data: got %0d %0d %0d want %0d %0d %0d", rsp_x, rsp_y, rsp_z, e.x, e.y, e.z);
    end
    checks++;
    if (st !== 1) begin
      errors++; $display("FAIL unit_start_pulses: got %0d want 1", st);
    end
    finish_rsp();
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL unit_release: got valid/busy=%b want 00", {rsp_valid, busy});
    end
  endtask

  typedef struct {
    logic signed [W-1:0] x;
    logic [DW-1:0]       d;
    logic signed [W-1:0] ex;
    int                  lat;
  } vec_t;

  task automatic test_scale();
    exp_t e; int lat, st; bit to;
    vec_t v[4];
    logic signed [W-1:0] rx;
    logic [DW-1:0] rd;
    v[0] = '{16'sd1000, 11'h600, 16'sd1500, 4};
    v[1] = '{-16'sd3,   11'h200, -16'sd2,   4};
    v[2] = '{16'sd1024, 11'h7FF, 16'sd2047, 13};
    v[3] = '{16'sd5,    11'h000, 16'sd0,    3};
    for (int i = 0; i < 4; i++) begin
      e.id = 1'b0; e.x = v[i].ex; e.y = scale(-v[i].x, v[i].d); e.z = scale(16'sd12345, v[i].d);
      e.lat = v[i].lat;
      sb.push_back(e);
      run_op(1'b0, v[i].x, -v[i].x, 16'sd12345, v[i].d, lat, st, to);
      e = sb.pop_front();
      checks++;
      if (to || lat !== e.lat) begin
        errors++; $display("FAIL scale_latency[%0d]: got %0d (timeout=%0b) want %0d", i, lat, to, e.lat);
      end
      checks++;
      if ({rsp_id, rsp_x, rsp_y, rsp_z} !== {e.id, e.x, e.y, e.z}) begin
        errors++; $display("FAIL scale_data[%0d]: got id=%b %0d %0d %0d want id=%b %0d %0d %0d",
                           i, rsp_id, rsp_x, rsp_y, rsp_z, e.id, e.x, e.y, e.z);
      end
      finish_rsp();
    end
    checks++;
    if (mul_x !== 16'sd5 || mul_d !== 11'h000) begin
      errors++; $display("FAIL operand_hold: got x=%0d d=%h want 5 000", mul_x, mul_d);
    end
    for (int i = 0; i < 4; i++) begin
      rx = W'($urandom);
      rd = DW'($urandom_range(0, 2047));
      e.id = 1'b1; e.x = scale(rx, rd); e.y = scale(~rx, rd); e.z = scale(rx >>> 3, rd);
      e.lat = nsteps(rd) + 3;
      sb.push_back(e);
      run_op(1'b1, rx, ~rx, rx >>> 3, rd, lat, st, to);
      e = sb.pop_front();
      checks++;
      if (to || lat !== e.lat || {rsp_id, rsp_x, rsp_y, rsp_z} !== {e.id, e.x, e.y, e.z}) begin
        errors++; $display("FAIL rand_op[%0d]: got lat=%0d id=%b %0d %0d %0d want lat=%0d id=%b %0d %0d %0d",
                           i, lat, rsp_id, rsp_x, rsp_y, rsp_z, e.lat, e.id, e.x, e.y, e.z);
      end
      finish_rsp();
    end
  endtask

  task automatic test_contention();
    exp_t e; int acc, rsp; bit g;
    logic signed [W-1:0] x0, x1;
    x0 = 16'sd100; x1 = -16'sd200; acc = 0; rsp = 0;
    req0_x = x0; req0_y = 16'sd1; req0_z = 16'sd2; req0_d = 11'h400;
    req1_x = x1; req1_y = 16'sd3; req1_z = 16'sd4; req1_d = 11'h600;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 200 && rsp < 4; cyc++) begin
      if (rsp_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL contention_unexpected_rsp: got id=%b x=%0d want none", rsp_id, rsp_x);
        end else begin
          e = sb.pop_front();
          if ({rsp_id, rsp_x, rsp_y, rsp_z} !== {e.id, e.x, e.y, e.z}) begin
            errors++; $display("FAIL contention_rsp[%0d]: got id=%b %0d %0d %0d want id=%b %0d %0d %0d",
                               rsp, rsp_id, rsp_x, rsp_y, rsp_z, e.id, e.x, e.y, e.z);
          end
        end
        rsp++;
      end
      if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
`ifdef SERIALMUL_ARB_RR_EN
        g = (req0_valid && req1_valid) ? ~model_last : req1_valid;
`else
        g = req0_valid ? 1'b0 : 1'b1;
`endif
        checks++;
        if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL contention_grant[%0d]: got ready1/0=%b want %b", acc, {req1_ready, req0_ready},
                             g ? 2'b10 : 2'b01);
        end
        e.id = g; e.lat = -1;
        e.x = g ? scale(x1, req1_d) : scale(x0, req0_d);
        e.y = g ? scale(16'sd3, req1_d) : scale(16'sd1, req0_d);
        e.z = g ? scale(16'sd4, req1_d) : scale(16'sd2, req0_d);
        sb.push_back(e);
        model_last = g;
        acc++;
        tick();
        if (g) begin x1 = x1 - 16'sd50; req1_x = x1; end
        else begin x0 = x0 + 16'sd100; req0_x = x0; end
`ifndef SERIALMUL_ARB_RR_EN
        if (acc == 3) req0_valid = 1'b0;
`endif
        if (acc == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      end else begin
        tick();
      end
    end
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp < 4 || sb.size() != 0) begin
      errors++; $display("FAIL contention_count: got %0d responses (%0d pending) want 4 (0)", rsp, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_backpressure();
    exp_t e; int lat, st, guard; bit to;
    e.id = 1'b0; e.x = 16'sd450; e.y = -16'sd30; e.z = 16'sd7; e.lat = 4;
    sb.push_back(e);
    run_op(1'b0, 16'sd300, -16'sd20, 16'sd5, 11'h600, lat, st, to);
    e = sb.pop_front();
    checks++;
    if (to || lat !== e.lat || {rsp_id, rsp_x, rsp_y, rsp_z} !== {e.id, e.x, e.y, e.z}) begin
      errors++; $display("FAIL bp_first: got lat=%0d id=%b %0d %0d %0d want lat=%0d id=%b %0d %0d %0d",
                         lat, rsp_id, rsp_x, rsp_y, rsp_z, e.lat, e.id, e.x, e.y, e.z);
    end
    req1_valid = 1'b1; req1_x = 16'sd77; req1_y = 16'sd0; req1_z = -16'sd1; req1_d = 11'h400;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b1100 || {rsp_x, rsp_y, rsp_z} !== {e.x, e.y, e.z}) begin
        errors++; $display("FAIL bp_hold[%0d]: got valid/busy/rdy=%b x=%0d want 1100 x=%0d", i,
                           {rsp_valid, busy, req0_ready, req1_ready}, rsp_x, e.x);
      end
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL bp_no_accept_on_handshake: got ready0/1=%b want 00", {req0_ready, req1_ready});
    end
    tick();
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
      errors++; $display("FAIL bp_next_accept: got rsp_valid=%b req1_ready=%b want 0 1", rsp_valid, req1_ready);
    end
    e.id = 1'b1; e.x = 16'sd77; e.y = 16'sd0; e.z = -16'sd1; e.lat = -1;
    sb.push_back(e);
    tick();
    model_last = 1'b1;
    req1_valid = 1'b0;
    guard = 0;
    while (rsp_valid !== 1'b1 && guard < 40) begin tick(); guard++; end
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || guard !== 3 || {rsp_id, rsp_x, rsp_y, rsp_z} !== {e.id, e.x, e.y, e.z}) begin
      errors++; $display("FAIL bp_second: got valid=%b lat=%0d id=%b x=%0d z=%0d want 1 3 id=%b x=%0d z=%0d",
                         rsp_valid, guard, rsp_id, rsp_x, rsp_z, e.id, e.x, e.z);
    end
    finish_rsp();
  endtask

  task automatic test_reset_mid_run();
    exp_t e; int lat, st, guard; bit to;
    req0_valid = 1'b1; req0_x = 16'sd500; req0_y = 16'sd6; req0_z = -16'sd9; req0_d = 11'h7FF;
    #1;
    guard = 0;
    while (req0_ready !== 1'b1 && guard < 40) begin tick(); guard++; end
    tick();
    model_last = 1'b0;
    req0_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre_busy: got %b want 1", busy);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, busy, mul_start, rsp_id} !== 4'b0000 || {mul_x, mul_y, mul_z, mul_d} !== '0 ||
        {rsp_x, rsp_y, rsp_z} !== '0) begin
      errors++; $display("FAIL rst_mid_run: got valid/busy/start/id=%b mul_x=%0d mul_d=%h rsp_x=%0d want all 0",
                         {rsp_valid, busy, mul_start, rsp_id}, mul_x, mul_d, rsp_x);
    end
    tick();
    rst = 1'b0;
    model_last = 1'b1;
    tick();
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL rst_no_stale_rsp: got valid/busy=%b want 00", {rsp_valid, busy});
    end
    e.id = 1'b1; e.x = 16'sd64; e.y = 16'sd0; e.z = -16'sd64; e.lat = 3;
    sb.push_back(e);
    run_op(1'b1, 16'sd64, 16'sd0, -16'sd64, 11'h400, lat, st, to);
    e = sb.pop_front();
    checks++;
    if (to || lat !== e.lat || {rsp_id, rsp_x, rsp_y, rsp_z} !== {e.id, e.x, e.y, e.z}) begin
      errors++; $display("FAIL rst_fresh_req: got lat=%0d id=%b %0d %0d %0d want lat=%0d id=%b %0d %0d %0d",
                         lat, rsp_id, rsp_x, rsp_y, rsp_z, e.lat, e.id, e.x, e.y, e.z);
    end
    finish_rsp();
  endtask

  task automatic test_spurious_done();
    exp_t e; int lat, st; bit to;
    force_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({busy, mul_start, rsp_valid} !== 3'b000) begin
        errors++; $display("FAIL spur_idle[%0d]: got busy/start/valid=%b want 000", i, {busy, mul_start, rsp_valid});
      end
    end
    force_done = 1'b0;
    e.id = 1'b1; e.x = 16'sd1234; e.y = -16'sd5; e.z = 16'sd0; e.lat = 3;
    sb.push_back(e);
    run_op(1'b1, 16'sd1234, -16'sd5, 16'sd0, 11'h400, lat, st, to);
    e = sb.pop_front();
    checks++;
    if (to || lat !== e.lat || {rsp_id, rsp_x, rsp_y, rsp_z} !== {e.id, e.x, e.y, e.z}) begin
      errors++; $display("FAIL spur_op: got lat=%0d id=%b x=%0d want lat=%0d id=%b x=%0d", lat, rsp_id, rsp_x,
                         e.lat, e.id, e.x);
    end
    force_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({busy, rsp_valid, mul_start} !== 3'b110 || {rsp_x, rsp_y} !== {e.x, e.y}) begin
        errors++; $display("FAIL spur_resp[%0d]: got busy/valid/start=%b x=%0d want 110 x=%0d", i,
                           {busy, rsp_valid, mul_start}, rsp_x, e.x);
      end
    end
    force_done = 1'b0;
    finish_rsp();
    checks++;
    if ({busy, rsp_valid} !== 2'b00) begin
      errors++; $display("FAIL spur_release: got busy/valid=%b want 00", {busy, rsp_valid});
    end
  endtask

  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_x = '0; req0_y = '0; req0_z = '0; req0_d = '0;
    req1_x = '0; req1_y = '0; req1_z = '0; req1_d = '0;
    #2 rst = 1'b1;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    model_last = 1'b1;
    tick();
    test_unit_scale();
    test_scale();
    test_contention();
    test_backpressure();
    test_reset_mid_run();
    test_spurious_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
